// File: rtl/msp430_spram_arbiter.sv
// rtl/msp430_spram_arbiter.sv - round-robin single-port RAM arbiter with burst hold; optional MSP430_SPRAM_ARB_PRIO0_EN
module msp430_spram_arbiter #(
   parameter int N         = 4,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_en,
   input  logic [N-1:0]         req_we,
   input  logic [N-1:0][AW-1:0] req_addr,
   input  logic [N-1:0][DW-1:0] req_din,
   output logic [N-1:0]         req_gnt,
   output logic [N-1:0]         req_rvalid,
   output logic [DW-1:0]        req_dout,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_din,
   input  logic [DW-1:0]        ram_dout
);

   localparam int IW = $clog2(N);

   logic          owner_vld;
   logic [IW-1:0] owner_idx;
   logic [7:0]    burst_cnt;
   logic [IW-1:0] rr_ptr;

   logic          keep;
   logic          win_vld;
   logic [IW-1:0] win_idx;
   logic          prio_hit;
   logic [IW:0]   cand;
   logic [N-1:0]  rd1_sel;
   logic [DW-1:0] dout_hold;

   // Winner selection: current owner keeps the port under the burst limit, else round-robin from rr_ptr
   always_comb begin
      keep     = owner_vld && req_en[owner_idx] && (burst_cnt < 8'(MAX_BURST));
      win_vld  = 1'b0;
      win_idx  = '0;
      prio_hit = 1'b0;
      cand     = '0;
      if (keep) begin
         win_vld = 1'b1;
         win_idx = owner_idx;
      end else begin
         // Walk downward so the candidate closest to rr_ptr is assigned last and wins
         for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(N))
               cand = cand - (IW + 1)'(N);
            if (req_en[cand[IW-1:0]]) begin
               win_vld = 1'b1;
               win_idx = cand[IW-1:0];
            end
         end
      end
`ifdef MSP430_SPRAM_ARB_PRIO0_EN
      // Port 0 preempts everyone; ownership bookkeeping of the other ports is left untouched
      if (req_en[0]) begin
         win_vld  = 1'b1;
         win_idx  = '0;
         prio_hit = 1'b1;
      end
`endif
   end

   // One-hot grant, forced low while in reset
   always_comb begin
      req_gnt = '0;
      if (rst && win_vld)
         req_gnt[win_idx] = 1'b1;
   end

   // Ownership, burst count and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_vld <= 1'b0;
         owner_idx <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
      end else if (prio_hit) begin
         owner_vld <= owner_vld;
      end else if (win_vld) begin
         if (keep) begin
            burst_cnt <= burst_cnt + 8'd1;
         end else begin
            owner_vld <= 1'b1;
            owner_idx <= win_idx;
            burst_cnt <= 8'd1;
            rr_ptr    <= (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
         end
      end else begin
         owner_vld <= 1'b0;
         burst_cnt <= '0;
      end
   end

   // RAM launch stage plus read-return tag pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         rd1_sel    <= '0;
         req_rvalid <= '0;
      end else begin
         ram_en     <= win_vld;
         ram_we     <= win_vld && req_we[win_idx];
         if (win_vld) begin
            ram_addr <= req_addr[win_idx];
            ram_din  <= req_din[win_idx];
         end
         rd1_sel    <= (win_vld && !req_we[win_idx]) ? req_gnt : '0;
         req_rvalid <= rd1_sel;
      end
   end

   // Keep the last returned word visible on the shared bus between returns
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         dout_hold <= '0;
      else if (|req_rvalid)
         dout_hold <= ram_dout;
   end

   assign req_dout = (|req_rvalid) ? ram_dout : dout_hold;

endmodule
